jstk_spi_slave: RTL

SPI Mode-0 slave that answers the 5-byte joystick transfer issued by our SPI master controller, acting as the device end of the same link. It oversamples SS/SCLK/MOSI with the system clock, receives one fixed-length frame MSB-first while shifting a 40-bit response frame out on MISO, and presents the received frame with a one-cycle valid strobe. It is used as a PmodJSTK stand-in for loopback testing and for board-to-board joystick emulation.

---
 rtl/jstk_spi_slave_pkg.sv | 29 ++
 rtl/jstk_spi_slave_if.sv | 29 ++
 rtl/spi_edge_sync.sv | 49 ++++
 rtl/jstk_spi_slave.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/jstk_spi_slave_pkg.sv
// ---------------------------------------------------------------------------
// jstk_spi_slave_pkg
// Definitions shared by the joystick SPI slave and the master controller it
// answers. This package is the home of what would otherwise live in
// jstk_spi_defs.vh:
//   - state_t        : FSM state encodings (IDLE=0, SHIFT=1, DONE=2)
//   - DEFAULT_NUM_BYTES / DEFAULT_SYNC_STAGES : default frame and sync sizes
//   - CMD_SET_LED / led_cmd() : PmodJSTK command byte (0b100000<led2><led1>)
// No ports; import with "import jstk_spi_slave_pkg::*;".
// ---------------------------------------------------------------------------
package jstk_spi_slave_pkg;

  localparam int DEFAULT_NUM_BYTES   = 5;
  localparam int DEFAULT_SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [7:0] CMD_SET_LED = 8'h80;

  // First byte of a PmodJSTK transfer: the LED command with both LED bits.
  function automatic logic [7:0] led_cmd(input logic led1, input logic led2);
    return CMD_SET_LED | {6'b000000, led2, led1};
  endfunction

endpackage

// File: rtl/jstk_spi_slave_if.sv
// ---------------------------------------------------------------------------
// jstk_spi_slave_if
// The four-wire SPI link plus the slave's MISO output enable.
//   ss      : slave select, active low (master drives)
//   sclk    : SPI clock, idle low, Mode 0 (master drives)
//   mosi    : master-to-slave data (master drives)
//   miso    : slave-to-master data (slave drives)
//   miso_oe : high while the slave is selected; tri-state control for miso
// Modports: master (drives ss/sclk/mosi), slave (drives miso/miso_oe).
// ---------------------------------------------------------------------------
interface jstk_spi_slave_if;

  logic ss;
  logic sclk;
  logic mosi;
  logic miso;
  logic miso_oe;

  modport master (
    output ss, sclk, mosi,
    input  miso, miso_oe
  );

  modport slave (
    input  ss, sclk, mosi,
    output miso, miso_oe
  );

endinterface

// File: rtl/spi_edge_sync.sv
// ---------------------------------------------------------------------------
// spi_edge_sync
// Brings one asynchronous SPI pin into the clk domain and flags its edges.
// Parameters:
//   SYNC_STAGES : flip-flops in the synchronizer chain (must be >= 2)
// Ports:
//   clk  : system clock
//   rst  : synchronous active-high reset (chain and edge flags cleared)
//   din  : asynchronous input pin
//   sync : synchronized copy of din
//   rise : one-cycle pulse, registered, after sync goes 0->1
//   fall : one-cycle pulse, registered, after sync goes 1->0
// Pin-to-flag latency is SYNC_STAGES+1 clk cycles.
// ---------------------------------------------------------------------------
module spi_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] chain;
  logic                   prev;

  // The edge flags are registered so every edge reaches the FSM with the
  // same fixed latency, which the MISO timing budget relies on. The chain
  // resets to 0: a pin that is already high after reset then shows a rise,
  // which IDLE ignores, instead of a fall that would start a bogus frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= '0;
      prev  <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], din};
      prev  <= chain[SYNC_STAGES-1];
      rise  <= chain[SYNC_STAGES-1] & ~prev;
      fall  <= ~chain[SYNC_STAGES-1] & prev;
    end
  end

  assign sync = chain[SYNC_STAGES-1];

endmodule

// File: rtl/jstk_spi_slave.sv
// ---------------------------------------------------------------------------
// jstk_spi_slave
// SPI Mode-0 slave for the fixed-length PmodJSTK transfer. Oversamples the
// SPI pins with clk, receives one frame MSB-first while shifting a response
// frame out on MISO, and presents the received frame with a valid strobe.
// Parameters:
//   NUM_BYTES   : bytes per frame, frame width W = 8*NUM_BYTES
//   SYNC_STAGES : flip-flops per input synchronizer (>= 2)
// Ports:
//   clk, rst   : system clock, synchronous active-high reset
//   spi        : SPI link (slave modport): ss, sclk, mosi in; miso, miso_oe out
//   txdata     : response frame, byte 0 in [W-1:W-8], captured at frame start
//   rxdata     : last complete received frame, byte 0 in [W-1:W-8]
//   rxvalid    : one-cycle pulse when rxdata updates
//   busy       : high from frame start until the return to IDLE
//   frame_err  : one-cycle pulse when ss deasserts mid-frame
// Optional (macro JSTK_SPI_SLAVE_BYTE_STB_EN defined):
//   rxbyte     : most recently completed byte
//   rxbyte_stb : one-cycle pulse after each completed byte, aborted frames too
// ---------------------------------------------------------------------------
module jstk_spi_slave
  import jstk_spi_slave_pkg::*;
#(
  parameter int NUM_BYTES   = DEFAULT_NUM_BYTES,
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic                   clk,
  input  logic                   rst,
  jstk_spi_slave_if.slave        spi,
  input  logic [8*NUM_BYTES-1:0] txdata,
  output logic [8*NUM_BYTES-1:0] rxdata,
  output logic                   rxvalid,
  output logic                   busy,
  output logic                   frame_err
`ifdef JSTK_SPI_SLAVE_BYTE_STB_EN
  ,
  output logic [7:0]             rxbyte,
  output logic                   rxbyte_stb
`endif
);

  localparam int              W         = 8 * NUM_BYTES;
  localparam int              BW        = $clog2(NUM_BYTES + 1);
  localparam logic [BW-1:0]   LAST_BYTE = BW'(NUM_BYTES - 1);
  localparam logic [BW-1:0]   BYTE_INC  = BW'(1);

  logic ss_sync_unused, ss_rise, ss_fall;
  logic sclk_sync_unused, sclk_rise, sclk_fall;
  logic mosi_sync, mosi_rise_unused, mosi_fall_unused;

  spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_ss_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (spi.ss),
    .sync (ss_sync_unused),
    .rise (ss_rise),
    .fall (ss_fall)
  );

  spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sclk_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (spi.sclk),
    .sync (sclk_sync_unused),
    .rise (sclk_rise),
    .fall (sclk_fall)
  );

  // MOSI goes through the same chain so it stays aligned with the SCLK flags.
  spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_mosi_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (spi.mosi),
    .sync (mosi_sync),
    .rise (mosi_rise_unused),
    .fall (mosi_fall_unused)
  );

  state_t          state, state_next;
  logic [W-1:0]    tx_sr, tx_sr_next;
  logic [W-1:0]    rx_sr, rx_sr_next;
  logic [2:0]      bit_cnt, bit_cnt_next;
  logic [BW-1:0]   byte_cnt, byte_cnt_next;
  logic [W-1:0]    rxdata_next;
  logic            rxvalid_next;
  logic            frame_err_next;
  logic [W-1:0]    rx_shifted;
  logic            frame_done;
  logic            miso_bit;
  logic            miso_en;
`ifdef JSTK_SPI_SLAVE_BYTE_STB_EN
  logic [7:0]      rxbyte_next;
  logic            rxbyte_stb_next;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      tx_sr     <= '0;
      rx_sr     <= '0;
      bit_cnt   <= '0;
      byte_cnt  <= '0;
      rxdata    <= '0;
      rxvalid   <= 1'b0;
      frame_err <= 1'b0;
`ifdef JSTK_SPI_SLAVE_BYTE_STB_EN
      rxbyte     <= '0;
      rxbyte_stb <= 1'b0;
`endif
    end else begin
      state     <= state_next;
      tx_sr     <= tx_sr_next;
      rx_sr     <= rx_sr_next;
      bit_cnt   <= bit_cnt_next;
      byte_cnt  <= byte_cnt_next;
      rxdata    <= rxdata_next;
      rxvalid   <= rxvalid_next;
      frame_err <= frame_err_next;
`ifdef JSTK_SPI_SLAVE_BYTE_STB_EN
      rxbyte     <= rxbyte_next;
      rxbyte_stb <= rxbyte_stb_next;
`endif
    end
  end

  always_comb begin
    state_next     = state;
    tx_sr_next     = tx_sr;
    rx_sr_next     = rx_sr;
    bit_cnt_next   = bit_cnt;
    byte_cnt_next  = byte_cnt;
    rxdata_next    = rxdata;
    rxvalid_next   = 1'b0;
    frame_err_next = 1'b0;
    rx_shifted     = {rx_sr[W-2:0], mosi_sync};
    frame_done     = 1'b0;
    miso_bit       = 1'b0;
    miso_en        = 1'b0;
    busy           = 1'b0;
`ifdef JSTK_SPI_SLAVE_BYTE_STB_EN
    rxbyte_next     = rxbyte;
    rxbyte_stb_next = 1'b0;
`endif

    case (state)
      IDLE: begin
        if (ss_fall) begin
          tx_sr_next    = txdata;
          rx_sr_next    = '0;
          bit_cnt_next  = '0;
          byte_cnt_next = '0;
          state_next    = SHIFT;
        end
      end

      SHIFT: begin
        miso_en  = 1'b1;
        miso_bit = tx_sr[W-1];
        busy     = 1'b1;
        if (sclk_rise) begin
          rx_sr_next   = rx_shifted;
          bit_cnt_next = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            byte_cnt_next = byte_cnt + BYTE_INC;
            frame_done    = (byte_cnt == LAST_BYTE);
`ifdef JSTK_SPI_SLAVE_BYTE_STB_EN
            rxbyte_next     = rx_shifted[7:0];
            rxbyte_stb_next = 1'b1;
`endif
          end
        end
        if (sclk_fall) begin
          tx_sr_next = {tx_sr[W-2:0], 1'b0};
        end
        // A final bit arriving together with the SS rise still completes
        // the frame, so the bit is folded in before SS is looked at.
        if (frame_done) begin
          if (ss_rise) begin
            rxdata_next  = rx_shifted;
            rxvalid_next = 1'b1;
            state_next   = IDLE;
          end else begin
            state_next = DONE;
          end
        end else if (ss_rise) begin
          frame_err_next = 1'b1;
          state_next     = IDLE;
        end
      end

      DONE: begin
        miso_en = 1'b1;
        busy    = 1'b1;
        if (ss_rise) begin
          rxdata_next  = rx_sr;
          rxvalid_next = 1'b1;
          state_next   = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign spi.miso    = miso_bit;
  assign spi.miso_oe = miso_en;

endmodule
